// File: rtl/ff_slice_cfg.sv
// Configurable flop slice: NUM_FF flops whose mode (enable, sync set/clear,
// async clear) is loaded through a serial, daisy-chainable configuration shift chain.
module ff_slice_cfg #(
  parameter int NUM_FF = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_en,
  input  logic              cfg_in,
  output logic              cfg_out,
  output logic              cfg_err,
  output logic              cfg_active,
  input  logic [NUM_FF-1:0] d,
  input  logic [NUM_FF-1:0] e,
  input  logic [NUM_FF-1:0] sr_n,
  output logic [NUM_FF-1:0] q
);

  localparam int CW    = 3 * NUM_FF;
  localparam int CNT_W = $clog2(CW + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CW);

  // state   | meaning
  // UNCFG   | no valid configuration committed; q held at 0
  // LOADING | shifting configuration bits into the shadow register
  // ACTIVE  | cfg committed; flops run in their configured modes
  typedef enum logic [1:0] {UNCFG, LOADING, ACTIVE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   shadow, cfg;
  logic [CNT_W-1:0] count;
  logic            commit, fail;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= UNCFG;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    fail      = 1'b0;
    if (cfg_en) begin
      state_nxt = LOADING;
    end else if (state == LOADING) begin
      if (count >= CNT_FULL) begin
        state_nxt = ACTIVE;
        commit    = 1'b1;
      end else begin
        state_nxt = UNCFG;
        fail      = 1'b1;
      end
    end
  end

  assign cfg_active = (state == ACTIVE);

  // Entering LOADING only clears the counter; shifting starts on the next edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow  <= '0;
      cfg     <= '0;
      count   <= '0;
      cfg_out <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      if (cfg_en && state != LOADING) begin
        count   <= '0;
        cfg_err <= 1'b0;
      end else if (cfg_en) begin
        shadow  <= {cfg_in, shadow[CW-1:1]};
        cfg_out <= shadow[0];
        if (count < CNT_FULL) count <= count + CNT_W'(1);
      end
      if (commit) cfg <= shadow;
      if (fail)   cfg_err <= 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_FF; i++) begin : g_ff
    logic [2:0] mode;
    logic       use_e, sync_set, sync_clr, aclr, clr, q_r;

    assign mode     = cfg[3*i +: 3];
    assign use_e    = (mode == 3'd1) || (mode == 3'd5) || (mode == 3'd6) || (mode == 3'd7);
    assign sync_set = (mode == 3'd2) || (mode == 3'd5);
    assign sync_clr = (mode == 3'd3) || (mode == 3'd6);
    assign aclr     = cfg_active && ((mode == 3'd4) || (mode == 3'd7)) && !sr_n[i];
    assign clr      = rst || aclr;

    always_ff @(posedge clk or posedge clr) begin
      if (clr)                         q_r <= 1'b0;
      else if (!cfg_active || cfg_en)  q_r <= 1'b0;
      else if (sync_set && !sr_n[i])   q_r <= 1'b1;
      else if (sync_clr && !sr_n[i])   q_r <= 1'b0;
      else if (!use_e || e[i])         q_r <= d[i];
    end

    assign q[i] = q_r;
  end

endmodule

// File: tb/tb_ff_slice_cfg.sv
// Self-checking bench for ff_slice_cfg (NUM_FF=8): table-driven flop vectors
// plus hand-written load, async-clear and reset sequences, checked via a scoreboard.
module tb_ff_slice_cfg;

  localparam int S_Q = 0, S_OUT = 1, S_ERR = 2, S_ACT = 3;

  logic       clk = 1'b0;
  logic       rst, cfg_en, cfg_in;
  logic       cfg_out, cfg_err, cfg_active;
  logic [7:0] d, e, sr_n, q;

  ff_slice_cfg #(.NUM_FF(8)) dut (
    .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_in(cfg_in),
    .cfg_out(cfg_out), .cfg_err(cfg_err), .cfg_active(cfg_active),
    .d(d), .e(e), .sr_n(sr_n), .q(q)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          sig;
    logic [31:0] exp;
  } exp_t;

  typedef struct {
    logic [7:0] d, e, sr_n, q;
  } vec_t;

  exp_t       sb[$];
  vec_t       vecs[8];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [23:0] m_shadow = '0;

  function automatic logic [31:0] sample(input int s);
    case (s)
      S_Q:     return {24'd0, q};
      S_OUT:   return {31'd0, cfg_out};
      S_ERR:   return {31'd0, cfg_err};
      default: return {31'd0, cfg_active};
    endcase
  endfunction

  function automatic logic [23:0] mk_cfg(input logic [31:0] nib);
    logic [23:0] r = '0;
    for (int i = 0; i < 8; i++) r[3*i +: 3] = nib[4*i +: 3];
    return r;
  endfunction

  task automatic push(input string name, input int sig, input logic [31:0] v);
    exp_t x;
    x.name = name; x.sig = sig; x.exp = v;
    sb.push_back(x);
  endtask

  task automatic drain();
    exp_t x;
    logic [31:0] got;
    while (sb.size() > 0) begin
      x   = sb.pop_front();
      got = sample(x.sig);
      n_checks++;
      if (got !== x.exp) begin
        n_fail++;
        $display("FAIL %s: got %0h expected %0h at %0t", x.name, got, x.exp, $time);
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    drain();
  endtask

  task automatic push_all_zero(input string tag);
    push({tag, "_q"}, S_Q, 0);
    push({tag, "_out"}, S_OUT, 0);
    push({tag, "_err"}, S_ERR, 0);
    push({tag, "_act"}, S_ACT, 0);
  endtask

  // Entry edge clears the counter without shifting; each later edge shifts one bit.
  task automatic load(input logic [63:0] data, input int n);
    cfg_en = 1'b1; cfg_in = 1'b0;
    push("entry_q", S_Q, 0);
    push("entry_err", S_ERR, 0);
    push("entry_act", S_ACT, 0);
    step();
    for (int k = 0; k < n; k++) begin
      cfg_in = data[k];
      push("shift_out", S_OUT, {31'd0, m_shadow[0]});
      if (k >= 24) push("passthru", S_OUT, {31'd0, data[k-24]});
      push("shift_act", S_ACT, 0);
      push("shift_q", S_Q, 0);
      m_shadow = {data[k], m_shadow[23:1]};
      step();
    end
    cfg_en = 1'b0; cfg_in = 1'b0;
    push("end_act", S_ACT, (n >= 24) ? 1 : 0);
    push("end_err", S_ERR, (n >= 24) ? 0 : 1);
    push("end_q", S_Q, 0);
    step();
  endtask

  task automatic apply(input string name, input logic [7:0] dv, input logic [7:0] ev,
                       input logic [7:0] sv, input logic [7:0] qv);
    d = dv; e = ev; sr_n = sv;
    push(name, S_Q, {24'd0, qv});
    push({name, "_act"}, S_ACT, 1);
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // flops configured as mode i for flop i
    vecs[0] = '{d: 8'hFF, e: 8'hFF, sr_n: 8'hFF, q: 8'hFF};
    vecs[1] = '{d: 8'h00, e: 8'h00, sr_n: 8'hFF, q: 8'hE2};
    vecs[2] = '{d: 8'h00, e: 8'h00, sr_n: 8'h00, q: 8'h26};
    vecs[3] = '{d: 8'hFF, e: 8'h00, sr_n: 8'hFF, q: 8'h3F};
    vecs[4] = '{d: 8'h00, e: 8'hFF, sr_n: 8'hAA, q: 8'h04};
    vecs[5] = '{d: 8'hA5, e: 8'h0F, sr_n: 8'hFF, q: 8'h05};
    vecs[6] = '{d: 8'h5A, e: 8'hF0, sr_n: 8'hFF, q: 8'h58};
    vecs[7] = '{d: 8'hFF, e: 8'h00, sr_n: 8'h00, q: 8'h25};

    rst = 1'b1; cfg_en = 1'b0; cfg_in = 1'b0;
    d = 8'hFF; e = 8'hFF; sr_n = 8'hFF;
    @(negedge clk);
    @(negedge clk);
    push_all_zero("reset");
    drain();
    rst = 1'b0;
    push("post_reset_act", S_ACT, 0);
    push("post_reset_q", S_Q, 0);
    step();

    // all dffe
    d = 8'h00; e = 8'h00;
    load({40'd0, mk_cfg(32'h11111111)}, 24);
    apply("dffe_cap", 8'hA5, 8'hFF, 8'hFF, 8'hA5);
    apply("dffe_hold", 8'h5A, 8'h00, 8'hFF, 8'hA5);

    // every mode, one per flop
    d = 8'h00; e = 8'h00; sr_n = 8'hFF;
    load({40'd0, mk_cfg(32'h76543210)}, 24);
    for (int i = 0; i < 8; i++)
      apply($sformatf("vec%0d", i), vecs[i].d, vecs[i].e, vecs[i].sr_n, vecs[i].q);

    // sync set / clear ignore e
    d = 8'h00; e = 8'h00; sr_n = 8'hFF;
    load({40'd0, mk_cfg(32'h00000032)}, 24);
    apply("sync_sr_d0", 8'h00, 8'h00, 8'h00, 8'h01);
    apply("sync_sr_d1", 8'hFF, 8'h00, 8'h00, 8'hFD);

    // async clear on flop 0
    d = 8'h00; e = 8'h00; sr_n = 8'hFF;
    load({40'd0, mk_cfg(32'h00000004)}, 24);
    apply("aclr_cap", 8'h01, 8'h00, 8'hFF, 8'h01);
    #2 sr_n = 8'hFE;
    #1 push("aclr_immediate", S_Q, 0); drain();
    @(negedge clk);
    push("aclr_held", S_Q, 0); drain();
    #2 sr_n = 8'hFF;
    #1 push("aclr_release_noedge", S_Q, 0); drain();
    step();
    push("aclr_recapture", S_Q, 8'h01); drain();

    // short load from ACTIVE, then recover
    d = 8'hFF; e = 8'hFF;
    load(64'h3FF, 10);
    for (int i = 0; i < 2; i++) begin
      push("short_err_sticky", S_ERR, 1);
      push("short_act", S_ACT, 0);
      push("short_q", S_Q, 0);
      step();
    end
    d = 8'h00; e = 8'h00;
    load({40'd0, mk_cfg(32'h11111111)}, 24);

    // 30-bit load: first 6 bits flow out, last 24 commit (all dffe)
    load({34'd0, mk_cfg(32'h11111111), 6'b101101}, 30);
    apply("long_dffe_hold", 8'hFF, 8'h00, 8'hFF, 8'h00);
    apply("long_dffe_cap", 8'h3C, 8'hFF, 8'hFF, 8'h3C);

    // reset during bit 12 of a load
    cfg_en = 1'b1; cfg_in = 1'b0;
    step();
    for (int k = 0; k < 11; k++) begin
      cfg_in = k[0];
      m_shadow = {k[0], m_shadow[23:1]};
      step();
    end
    cfg_in = 1'b1;
    #2 rst = 1'b1;
    #1 push_all_zero("rst_mid"); drain();
    @(negedge clk);
    push_all_zero("rst_held"); drain();
    rst = 1'b0; cfg_en = 1'b0; m_shadow = '0;
    for (int i = 0; i < 3; i++) begin
      push("rst_idle_act", S_ACT, 0);
      push("rst_idle_q", S_Q, 0);
      step();
    end
    load({40'd0, mk_cfg(32'h00000000)}, 24);
    apply("after_rst_dff", 8'h96, 8'h00, 8'hFF, 8'h96);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ff_slice_cfg.md
FF_SLICE_CFG -- requirements
Module: ff_slice_cfg

Interface
REQ-001 The block SHALL have parameter NUM_FF, default 8, giving the number of configurable flops in the slice (range 1..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all sequential logic is rising-edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port cfg_en, input, 1 bit: configuration shift enable.
REQ-005 The block SHALL have port cfg_in, input, 1 bit: serial configuration data.
REQ-006 The block SHALL have port cfg_out, output, 1 bit: serial chain output, for daisy-chaining slices.
REQ-007 The block SHALL have port cfg_err, output, 1 bit: sticky short-load error.
REQ-008 The block SHALL have port cfg_active, output, 1 bit: high when the slice is configured and running.
REQ-009 The block SHALL have port d, input, NUM_FF bits: flop data inputs.
REQ-010 The block SHALL have port e, input, NUM_FF bits: per-flop clock enable, active-high.
REQ-011 The block SHALL have port sr_n, input, NUM_FF bits: per-flop set/reset, active-low; its meaning is selected by mode.
REQ-012 The block SHALL have port q, output, NUM_FF bits: flop outputs.

Function
REQ-013 Each flop i SHALL take its mode from cfg[3i+2:3i], where cfg is the active configuration register of width 3*NUM_FF.
REQ-014 Mode encoding SHALL be:
- 0 = dff
- 1 = dffe
- 2 = dffh: sync set on sr_n=0
- 3 = dffl: sync clear on sr_n=0
- 4 = dffr: async clear on sr_n=0
- 5 = dffeh
- 6 = dffel
- 7 = dffer
REQ-015 Priority within a flop SHALL be: async clear, then sync set/clear, then enable, then d; sync set/clear acts regardless of e.
REQ-016 In modes that do not use e, e SHALL be ignored; in modes that do not use sr_n, sr_n SHALL be ignored.
REQ-017 Mode 4/7 async clear SHALL force q[i]=0 immediately on sr_n[i]=0 and hold it while low; normal capture resumes at the first rising clk edge after release.
REQ-018 The controller SHALL have three states: UNCFG, LOADING, ACTIVE.
REQ-019 Transitions SHALL be:
- any state with cfg_en=1 -> LOADING; the bit counter clears on entry.
- LOADING with cfg_en=0 and count >= 3*NUM_FF -> ACTIVE; shadow is copied to cfg on that edge.
- LOADING with cfg_en=0 and count < 3*NUM_FF -> UNCFG; cfg_err is set and cfg is unchanged.
REQ-020 Each cycle in LOADING with cfg_en=1, the shadow register SHALL shift right by one:
- cfg_in enters the MSB;
- cfg_out is registered from the old shadow[0];
- the counter increments and saturates at 3*NUM_FF.
REQ-021 The first bit shifted in after a full load SHALL land in shadow[0]; bits beyond 3*NUM_FF SHALL keep shifting through to cfg_out.
REQ-022 Outside ACTIVE, all q SHALL be held at 0, flops SHALL ignore d, e and sr_n, and cfg_active SHALL be 0.
REQ-023 cfg_active SHALL be 1 exactly while the state is ACTIVE; the first flop capture in ACTIVE occurs on the edge after the commit edge.
REQ-024 Re-entering LOADING from ACTIVE SHALL clear all q to 0 on that edge and keep the old cfg until the next successful commit.
REQ-025 cfg_err SHALL clear on entry to LOADING; it remains 1 after a failed load until the next load or reset.

Reset
REQ-026 While rst=1, the block SHALL hold: state=UNCFG, cfg=0, shadow=0, counter=0, q=0, cfg_out=0, cfg_err=0, cfg_active=0.
REQ-027 rst SHALL take effect asynchronously, including mid-load; release SHALL be synchronous to clk, and the next edge SHALL see state UNCFG.

Verification
REQ-028 NUM_FF=8: shift 24 bits encoding all flops as mode 1, then drop cfg_en -> cfg_active=1 next cycle; d=0xA5 with e=0xFF gives q=0xA5 one edge later; with e=0x00, q holds.
REQ-029 Flop0 configured mode 2, flop1 mode 3, d=0x00/0xFF, sr_n=0x00 -> q[0]=1 and q[1]=0 after one edge, even with e=0.
REQ-030 Flop0 configured mode 4, q[0]=1; pulse sr_n[0]=0 mid-cycle -> q[0]=0 without a clk edge; it recaptures d on the first edge after release.
REQ-031 Shift only 10 bits then drop cfg_en -> cfg_err=1, state UNCFG, q=0; a following full 24-bit load -> cfg_err=0 and cfg_active=1.
REQ-032 Shift 30 bits -> the first 6 bits appear on cfg_out, delayed by 25 cycles; the committed cfg equals the last 24 bits.
REQ-033 Assert rst during bit 12 of a load -> all outputs 0 at once; after release, cfg_active stays 0 until a new full load completes.
